// File: rtl/saturn_pkg.sv
// rtl/saturn_pkg.sv - shared FSM states and phase constants for the saturn phase sequencer
package saturn_pkg;

    // Sequencer control states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } seq_state_t;

    // Default geometry of the sequencer.
    localparam int NPHASES_DEF = 4;
    localparam int CTR_W_DEF   = 32;

    // Named phases of a default four-phase machine cycle.
    localparam int PH_BUS_SEND = 0;
    localparam int PH_BUS_RECV = 1;
    localparam int PH_DEC      = 2;
    localparam int PH_EXEC     = 3;

endpackage

// File: rtl/saturn_phase_sequencer.sv
// rtl/saturn_phase_sequencer.sv - machine-cycle phase sequencer with run/step/stall/halt; cycle limit enabled by SATURN_CYCLE_LIMIT_EN
module saturn_phase_sequencer
    import saturn_pkg::*;
#(
    parameter  int NPHASES = NPHASES_DEF,
    parameter  int CTR_W   = CTR_W_DEF,
    localparam int PH_W    = $clog2(NPHASES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic [NPHASES-1:0] i_hold_mask,
    input  logic               i_halt_req,
    input  logic [CTR_W-1:0]   i_max_cycle,
    output logic [NPHASES-1:0] o_phase_en,
    output logic [PH_W-1:0]    o_phase,
    output logic [CTR_W-1:0]   o_cycle,
    output logic               o_cycle_start,
    output logic               o_halt,
    output logic               o_running
);

    // First and last phase indices of a machine cycle.
    localparam logic [PH_W-1:0] PH_FIRST = PH_W'(PH_BUS_SEND);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(NPHASES - 1);

    // Registered state.
    seq_state_t         state;
    logic [PH_W-1:0]    phase;
    logic [CTR_W-1:0]   cycle;
    logic [NPHASES-1:0] phase_en;
    logic               halt_q;
    logic               running_q;
    // Set once the current RUN/STEP session has issued at least one phase,
    // so that sitting on the last phase right after entry is not mistaken
    // for a completed cycle.
    logic               cycle_open;

    // Combinational helpers.
    logic [PH_W-1:0]    phase_next;
    logic               hold;
    logic               at_boundary;
    logic               limit_hit;

    // Next phase with wrap-around, stall hold decision and cycle-boundary detect.
    always_comb begin
        phase_next  = (phase == PH_LAST) ? PH_FIRST : phase + PH_W'(1);
        hold        = i_stall & i_hold_mask[phase_next];
        at_boundary = cycle_open & (phase == PH_LAST);
    end

`ifdef SATURN_CYCLE_LIMIT_EN
    // A finished cycle whose number equals the limit stops the machine.
    assign limit_hit = (cycle == i_max_cycle);
`else
    // No cycle limit in this build; the limit input is intentionally ignored.
    logic unused_max_cycle;
    assign unused_max_cycle = ^i_max_cycle;
    assign limit_hit        = 1'b0;
`endif

    // Control FSM together with the inline phase and cycle counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= PH_LAST;
            cycle      <= '1;
            phase_en   <= '0;
            halt_q     <= 1'b0;
            running_q  <= 1'b0;
            cycle_open <= 1'b0;
        end else begin
            // Enables are single-clock pulses unless an advance reasserts one.
            phase_en <= '0;
            case (state)
                IDLE: begin
                    if (i_halt_req) begin
                        state  <= HALT;
                        halt_q <= 1'b1;
                    end else if (i_run) begin
                        state      <= RUN;
                        running_q  <= 1'b1;
                        cycle_open <= 1'b0;
                    end else if (i_step) begin
                        state      <= STEP;
                        running_q  <= 1'b1;
                        cycle_open <= 1'b0;
                    end
                end
                RUN, STEP: begin
                    if (i_halt_req || (at_boundary && limit_hit)) begin
                        // Halt wins over everything and issues no pulse.
                        state     <= HALT;
                        halt_q    <= 1'b1;
                        running_q <= 1'b0;
                    end else if (at_boundary && ((state == STEP) || !i_run)) begin
                        // Only a fully completed cycle may drop back to IDLE.
                        state     <= IDLE;
                        running_q <= 1'b0;
                    end else if (!hold) begin
                        phase      <= phase_next;
                        phase_en   <= NPHASES'(1) << phase_next;
                        cycle_open <= 1'b1;
                        if (phase_next == PH_FIRST) begin
                            cycle <= cycle + CTR_W'(1);
                        end
                    end
                end
                HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_phase_en    = phase_en;
    assign o_phase       = phase;
    assign o_cycle       = cycle;
    assign o_cycle_start = phase_en[PH_BUS_SEND];
    assign o_halt        = halt_q;
    assign o_running     = running_q;

endmodule

// File: tb/tb_saturn_phase_sequencer.sv
// tb/tb_saturn_phase_sequencer.sv - scoreboard bench for saturn_phase_sequencer against a phase-count reference model
module tb_saturn_phase_sequencer;

    localparam int NP = 4;
    localparam int CW = 32;

    localparam int MD_IDLE = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_STEP = 2;
    localparam int MD_HALT = 3;

`ifdef SATURN_CYCLE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_run = 1'b0;
    logic          i_step = 1'b0;
    logic          i_stall = 1'b0;
    logic [NP-1:0] i_hold_mask = '0;
    logic          i_halt_req = 1'b0;
    logic [CW-1:0] i_max_cycle = 32'd1000;
    logic [NP-1:0] o_phase_en;
    logic [1:0]    o_phase;
    logic [CW-1:0] o_cycle;
    logic          o_cycle_start;
    logic          o_halt;
    logic          o_running;

    saturn_phase_sequencer #(
        .NPHASES (NP),
        .CTR_W   (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_run         (i_run),
        .i_step        (i_step),
        .i_stall       (i_stall),
        .i_hold_mask   (i_hold_mask),
        .i_halt_req    (i_halt_req),
        .i_max_cycle   (i_max_cycle),
        .o_phase_en    (o_phase_en),
        .o_phase       (o_phase),
        .o_cycle       (o_cycle),
        .o_cycle_start (o_cycle_start),
        .o_halt        (o_halt),
        .o_running     (o_running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  pe;
        logic [1:0]  ph;
        logic [31:0] cyc;
        logic        halt;
        logic        run;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode, current phase, cycle number and the count of
    // phases still owed in the open cycle (0 means a cycle just completed).
    int     m_mode  = MD_IDLE;
    int     m_phase = NP - 1;
    longint m_cycle = 64'h0000_0000_FFFF_FFFF;
    int     m_left  = 0;

    task automatic model_edge(output exp_t e);
        int nxt;
        logic [3:0] pulse;
        pulse = '0;
        if (!reset) begin
            m_mode  = MD_IDLE;
            m_phase = NP - 1;
            m_cycle = 64'h0000_0000_FFFF_FFFF;
            m_left  = 0;
        end else if (m_mode != MD_HALT && i_halt_req) begin
            m_mode = MD_HALT;
        end else if (m_mode == MD_IDLE) begin
            if (i_run) begin
                m_mode = MD_RUN;
                m_left = NP;
            end else if (i_step) begin
                m_mode = MD_STEP;
                m_left = NP;
            end
        end else if (m_mode == MD_RUN || m_mode == MD_STEP) begin
            if (m_left == 0 && LIMIT_EN && m_cycle == {32'd0, i_max_cycle}) begin
                m_mode = MD_HALT;
            end else if (m_left == 0 && (m_mode == MD_STEP || !i_run)) begin
                m_mode = MD_IDLE;
            end else begin
                nxt = (m_phase + 1) % NP;
                if (!(i_stall && i_hold_mask[nxt])) begin
                    m_phase    = nxt;
                    pulse[nxt] = 1'b1;
                    if (nxt == 0) begin
                        m_cycle = (m_cycle + 1) % 64'h0000_0001_0000_0000;
                        m_left  = NP;
                    end
                    m_left = m_left - 1;
                end
            end
        end
        e.pe   = pulse;
        e.ph   = m_phase[1:0];
        e.cyc  = m_cycle[31:0];
        e.halt = (m_mode == MD_HALT);
        e.run  = (m_mode == MD_RUN) || (m_mode == MD_STEP);
    endtask

    // Apply one clock's worth of inputs and queue the expected response.
    task automatic drive(input logic rst, input logic run, input logic step,
                         input logic stall, input logic [3:0] mask,
                         input logic hreq, input logic [31:0] maxc);
        exp_t e;
        @(posedge clk);
        #2;
        reset       = rst;
        i_run       = run;
        i_step      = step;
        i_stall     = stall;
        i_hold_mask = mask;
        i_halt_req  = hreq;
        i_max_cycle = maxc;
        model_edge(e);
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs with the queued expectation every clock.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {o_phase_en, o_phase, o_cycle, o_halt, o_running};
                n_checks++;
                if (got === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t got pe=%b ph=%0d cyc=%h halt=%b run=%b expected pe=%b ph=%0d cyc=%h halt=%b run=%b",
                             $time, o_phase_en, o_phase, o_cycle, o_halt, o_running,
                             e.pe, e.ph, e.cyc, e.halt, e.run);
                end
                n_checks++;
                if (o_cycle_start === e.pe[0]) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_start t=%0t got %b expected %b", $time, o_cycle_start, e.pe[0]);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic        run_s;
        logic [31:0] maxc;
        run_s = 1'b0;

        // Reset state.
        repeat (2) drive(0, 0, 0, 0, 4'b0000, 0, 32'd1000);
        // Release reset while running: 0001,0010,0100,1000 repeating.
        repeat (14) drive(1, 1, 0, 0, 4'b0000, 0, 32'd1000);
        // Stall with phase 2 held, then resume.
        repeat (3) drive(1, 1, 0, 1, 4'b0100, 0, 32'd1000);
        repeat (6) drive(1, 1, 0, 0, 4'b0000, 0, 32'd1000);
        // Drop run mid-cycle: finish the cycle, then IDLE.
        repeat (8) drive(1, 0, 0, 0, 4'b0000, 0, 32'd1000);
        // Single step.
        drive(1, 0, 1, 0, 4'b0000, 0, 32'd1000);
        repeat (8) drive(1, 0, 0, 0, 4'b0000, 0, 32'd1000);
        // Step lengthened by stalls.
        drive(1, 0, 1, 0, 4'b0000, 0, 32'd1000);
        repeat (12) drive(1, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom), 0, 32'd1000);
        repeat (6) drive(1, 0, 0, 0, 4'b0000, 0, 32'd1000);
        // Run and step together -> RUN, drop run after phase 1.
        drive(1, 1, 1, 0, 4'b0000, 0, 32'd1000);
        repeat (2) drive(1, 1, 0, 0, 4'b0000, 0, 32'd1000);
        repeat (6) drive(1, 0, 0, 0, 4'b0000, 0, 32'd1000);
        // Halt request mid-cycle, then reset recovers.
        repeat (4) drive(1, 1, 0, 0, 4'b0000, 0, 32'd1000);
        drive(1, 1, 0, 1, 4'b1111, 1, 32'd1000);
        repeat (4) drive(1, 1, 1, 0, 4'b0000, 0, 32'd1000);
        repeat (2) drive(0, 1, 0, 0, 4'b0000, 0, 32'd1000);
        // Cycle limit of 2.
        repeat (20) drive(1, 1, 0, 0, 4'b0000, 0, 32'd2);
        repeat (2) drive(0, 0, 0, 0, 4'b0000, 0, 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_s = ~run_s;
            maxc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : 32'hFFFF_0000;
            drive(1'($urandom_range(0, 79) != 0),
                  run_s,
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) == 0),
                  4'($urandom),
                  1'($urandom_range(0, 299) == 0),
                  maxc);
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
